apb_conv_ctrl_mc: RTL and testbench

APB_CONV_CTRL_MC -- requirements
Module: apb_conv_ctrl_mc

---
 rtl/apb_conv_pkg.sv | 30 +++
 rtl/apb_conv_ch_regs.sv | 56 +++++
 rtl/apb_conv_ctrl_mc.sv | 199 +++++++++++++++++++
 tb/tb_apb_conv_ctrl_mc.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_conv_pkg.sv
// Shared definitions for the APB convolution-engine control block.
package apb_conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_t;

    // Per-channel register offsets within a channel window
    localparam logic [4:0] OFF_CTRL   = 5'h00;
    localparam logic [4:0] OFF_SRC    = 5'h04;
    localparam logic [4:0] OFF_DST    = 5'h08;
    localparam logic [4:0] OFF_LEN    = 5'h0C;
    localparam logic [4:0] OFF_STATUS = 5'h10;

    // Global registers
    localparam logic [11:0] ADDR_ID         = 12'h100;
    localparam logic [11:0] ADDR_IRQ_STATUS = 12'h104;
    localparam logic [31:0] ID_VALUE        = 32'h434F_4E56;

    // Channel windows are CH_STRIDE bytes apart, starting at 0x000
    localparam int unsigned CH_SHIFT  = 5;
    localparam int unsigned CH_STRIDE = 1 << CH_SHIFT;

    function automatic logic [2:0] ch_index(input logic [11:0] addr);
        return addr[CH_SHIFT +: 3];
    endfunction

endpackage

// File: rtl/apb_conv_ch_regs.sv
// Register set for one convolution channel: CTRL, SRC, DST, LEN, STATUS flags.
// wr_en is only asserted for writes already validated by the bus decoder.
module apb_conv_ch_regs
    import apb_conv_pkg::*;
#(
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [4:0]       off,
    input  logic [31:0]      wdata,
    input  logic             done,
    input  logic             err,
    output logic             start,
    output logic [31:0]      src,
    output logic [31:0]      dst,
    output logic [LEN_W-1:0] len,
    output logic             irq_en,
    output logic             done_flag,
    output logic             err_flag
);

    logic clr_done;
    logic clr_err;

    assign clr_done = wr_en && (off == OFF_STATUS) && wdata[1];
    assign clr_err  = wr_en && (off == OFF_STATUS) && wdata[2];

    // Register writes, start pulse generation and sticky status flags (set beats clear)
    always_ff @(posedge clk) begin
        if (rst) begin
            start     <= 1'b0;
            src       <= '0;
            dst       <= '0;
            len       <= '0;
            irq_en    <= 1'b0;
            done_flag <= 1'b0;
            err_flag  <= 1'b0;
        end else begin
            start     <= wr_en && (off == OFF_CTRL) && wdata[0];
            done_flag <= done | (done_flag & ~clr_done);
            err_flag  <= err  | (err_flag  & ~clr_err);
            if (wr_en) begin
                case (off)
                    OFF_CTRL: irq_en <= wdata[1];
                    OFF_SRC:  src    <= wdata;
                    OFF_DST:  dst    <= wdata;
                    OFF_LEN:  len    <= wdata[LEN_W-1:0];
                    default:  ;
                endcase
            end
        end
    end

endmodule

// File: rtl/apb_conv_ctrl_mc.sv
// APB slave controlling NUM_CH convolution engines: bus FSM, address decode,
// error checking and read mux; per-channel state lives in apb_conv_ch_regs.
module apb_conv_ctrl_mc
    import apb_conv_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned LEN_W       = 16
) (
    input  logic                         HCLK,
    input  logic                         HRESET,
    input  logic [11:0]                  PADDR,
    input  logic [31:0]                  PWDATA,
    input  logic                         PWRITE,
    input  logic                         PSEL,
    input  logic                         PENABLE,
    output logic [31:0]                  PRDATA,
    output logic                         PREADY,
    output logic                         PSLVERR,
    output logic [NUM_CH-1:0]            ch_start,
    output logic [NUM_CH-1:0][31:0]      ch_src,
    output logic [NUM_CH-1:0][31:0]      ch_dst,
    output logic [NUM_CH-1:0][LEN_W-1:0] ch_len,
    input  logic [NUM_CH-1:0]            ch_busy,
    input  logic [NUM_CH-1:0]            ch_done,
    input  logic [NUM_CH-1:0]            ch_err,
    output logic                         irq
);

    apb_state_t  state, next_state;
    logic [1:0]  wcnt, next_wcnt;
    logic        complete;

    logic [11:0] word_addr;
    logic [2:0]  ch_idx;
    logic [4:0]  off;
    logic        dec_err;
    logic [31:0] rdata;
    logic        wr_ok;

    logic             sel_busy;
    logic [31:0]      sel_src;
    logic [31:0]      sel_dst;
    logic [LEN_W-1:0] sel_len;
    logic             sel_irq_en;
    logic             sel_done;
    logic             sel_err;

    logic [NUM_CH-1:0] irq_en;
    logic [NUM_CH-1:0] done_flag;
    logic [NUM_CH-1:0] err_flag;
    logic [NUM_CH-1:0] irq_pend;

    logic unused_addr_bits;
    assign unused_addr_bits = ^PADDR[1:0];

    assign word_addr = {PADDR[11:2], 2'b00};
    assign ch_idx    = ch_index(PADDR);
    assign off       = {PADDR[4:2], 2'b00};
    assign irq_pend  = done_flag & irq_en;

    // Bus state and wait counter
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= ST_IDLE;
            wcnt  <= '0;
        end else begin
            state <= next_state;
            wcnt  <= next_wcnt;
        end
    end

    // APB phase tracking; completion in the ACCESS cycle numbered WAIT_STATES+1
    always_comb begin
        next_state = state;
        next_wcnt  = wcnt;
        complete   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (PSEL && !PENABLE) next_state = ST_SETUP;
            end
            ST_SETUP: begin
                if (PSEL && PENABLE) begin
                    next_state = ST_ACCESS;
                    next_wcnt  = '0;
                end else if (!PSEL) begin
                    next_state = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (!(PSEL && PENABLE)) begin
                    next_state = ST_IDLE;
                end else if (wcnt == 2'(WAIT_STATES)) begin
                    complete   = !HRESET;
                    next_state = ST_IDLE;
                end else begin
                    next_wcnt = wcnt + 2'd1;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Select the addressed channel's state for checking and readback
    always_comb begin
        sel_busy   = 1'b0;
        sel_src    = '0;
        sel_dst    = '0;
        sel_len    = '0;
        sel_irq_en = 1'b0;
        sel_done   = 1'b0;
        sel_err    = 1'b0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (ch_idx == c[2:0]) begin
                sel_busy   = ch_busy[c];
                sel_src    = ch_src[c];
                sel_dst    = ch_dst[c];
                sel_len    = ch_len[c];
                sel_irq_en = irq_en[c];
                sel_done   = done_flag[c];
                sel_err    = err_flag[c];
            end
        end
    end

    // Address decode, error classification and read data mux
    always_comb begin
        dec_err = 1'b0;
        rdata   = '0;
        if (PADDR[11:8] == 4'h1) begin
            if (word_addr == ADDR_ID) begin
                dec_err = PWRITE;
                rdata   = ID_VALUE;
            end else if (word_addr == ADDR_IRQ_STATUS) begin
                dec_err = PWRITE;
                rdata[NUM_CH-1:0] = irq_pend;
            end else begin
                dec_err = 1'b1;
            end
        end else if (PADDR[11:8] != 4'h0 || 32'(ch_idx) >= NUM_CH || off > OFF_STATUS) begin
            dec_err = 1'b1;
        end else begin
            case (off)
                OFF_CTRL: begin
                    dec_err  = PWRITE && PWDATA[0] && (sel_busy || sel_len == '0);
                    rdata[1] = sel_irq_en;
                end
                OFF_SRC: begin
                    dec_err = PWRITE && sel_busy;
                    rdata   = sel_src;
                end
                OFF_DST: begin
                    dec_err = PWRITE && sel_busy;
                    rdata   = sel_dst;
                end
                OFF_LEN: begin
                    dec_err = PWRITE && sel_busy;
                    rdata[LEN_W-1:0] = sel_len;
                end
                default: begin
                    rdata[2:0] = {sel_err, sel_done, sel_busy};
                end
            endcase
        end
    end

    assign PREADY  = complete;
    assign PSLVERR = complete && dec_err;
    assign PRDATA  = (complete && !PWRITE && !dec_err) ? rdata : '0;
    assign wr_ok   = complete && PWRITE && !dec_err;

    // Interrupt is registered from the pending flags
    always_ff @(posedge HCLK) begin
        if (HRESET) irq <= 1'b0;
        else        irq <= |irq_pend;
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        apb_conv_ch_regs #(
            .LEN_W(LEN_W)
        ) u_regs (
            .clk       (HCLK),
            .rst       (HRESET),
            .wr_en     (wr_ok && (ch_idx == 3'(c))),
            .off       (off),
            .wdata     (PWDATA),
            .done      (ch_done[c]),
            .err       (ch_err[c]),
            .start     (ch_start[c]),
            .src       (ch_src[c]),
            .dst       (ch_dst[c]),
            .len       (ch_len[c]),
            .irq_en    (irq_en[c]),
            .done_flag (done_flag[c]),
            .err_flag  (err_flag[c])
        );
    end

endmodule

// File: tb/tb_apb_conv_ctrl_mc.sv
// Directed table-driven bench for apb_conv_ctrl_mc (NUM_CH=4, WAIT_STATES=1, LEN_W=16).
module tb_apb_conv_ctrl_mc;

    localparam int NCH = 4;
    localparam int WS  = 1;

    logic              HCLK = 1'b0;
    logic              HRESET;
    logic [11:0]       PADDR;
    logic [31:0]       PWDATA;
    logic              PWRITE, PSEL, PENABLE;
    logic [31:0]       PRDATA;
    logic              PREADY, PSLVERR;
    logic [NCH-1:0]    ch_start;
    logic [NCH-1:0][31:0] ch_src, ch_dst;
    logic [NCH-1:0][15:0] ch_len;
    logic [NCH-1:0]    ch_busy, ch_done, ch_err;
    logic              irq;

    int n_vec = 0;
    int n_bad = 0;
    int start_total = 0;

    apb_conv_ctrl_mc #(.NUM_CH(NCH), .WAIT_STATES(WS), .LEN_W(16)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .PADDR(PADDR), .PWDATA(PWDATA),
        .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .ch_start(ch_start), .ch_src(ch_src), .ch_dst(ch_dst), .ch_len(ch_len),
        .ch_busy(ch_busy), .ch_done(ch_done), .ch_err(ch_err), .irq(irq)
    );

    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) start_total += $countones(ch_start);

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One APB transfer; done_mask is driven on ch_done exactly during the completion cycle
    task automatic apb_xfer(input bit wr, input logic [11:0] addr, input logic [31:0] wd,
                            input logic [NCH-1:0] done_mask,
                            output logic [31:0] rd, output logic err, output int lat);
        bit got;
        got = 0; rd = '0; err = 1'b0; lat = 0;
        @(negedge HCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
        @(negedge HCLK);
        PENABLE = 1'b1;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge HCLK);
            lat++;
            if (PREADY) begin
                got = 1;
                rd = PRDATA;
                err = PSLVERR;
                ch_done = done_mask;
            end
        end
        if (!got) begin
            n_vec++;
            n_bad++;
            $display("FAIL pready_timeout addr 0x%03h: got no PREADY expected PREADY within 10 cycles", addr);
        end
        @(negedge HCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; ch_done = '0;
    endtask

    task automatic wr_chk(input string name, input logic [11:0] addr, input logic [31:0] wd,
                          input logic [NCH-1:0] done_mask);
        logic [31:0] rd; logic err; int lat;
        apb_xfer(1'b1, addr, wd, done_mask, rd, err, lat);
        check({name, " slverr"}, {31'b0, err}, 32'h0);
    endtask

    task automatic rd_chk(input string name, input logic [11:0] addr, input logic [31:0] exp);
        logic [31:0] rd; logic err; int lat;
        apb_xfer(1'b0, addr, '0, '0, rd, err, lat);
        check({name, " rdata"}, rd, exp);
    endtask

    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  busy;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    vec_t vecs[22];

    initial begin
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          rdy;
        int          s0;

        vecs[0]  = '{1'b1, 12'h024, 32'h1000_0000, 4'h0, 32'h0,         1'b0};
        vecs[1]  = '{1'b0, 12'h024, 32'h0,         4'h0, 32'h1000_0000, 1'b0};
        vecs[2]  = '{1'b0, 12'h100, 32'h0,         4'h0, 32'h434F_4E56, 1'b0};
        vecs[3]  = '{1'b0, 12'h1F0, 32'h0,         4'h0, 32'h0,         1'b1};
        vecs[4]  = '{1'b0, 12'h0A0, 32'h0,         4'h0, 32'h0,         1'b1};
        vecs[5]  = '{1'b1, 12'h104, 32'h1,         4'h0, 32'h0,         1'b1};
        vecs[6]  = '{1'b1, 12'h04C, 32'h5,         4'h4, 32'h0,         1'b1};
        vecs[7]  = '{1'b0, 12'h04C, 32'h0,         4'h0, 32'h0,         1'b0};
        vecs[8]  = '{1'b1, 12'h040, 32'h1,         4'h0, 32'h0,         1'b1};
        vecs[9]  = '{1'b1, 12'h048, 32'hDEAD_BEEF, 4'h4, 32'h0,         1'b1};
        vecs[10] = '{1'b1, 12'h04C, 32'hFFFF_0007, 4'h0, 32'h0,         1'b0};
        vecs[11] = '{1'b0, 12'h04C, 32'h0,         4'h0, 32'h7,         1'b0};
        vecs[12] = '{1'b1, 12'h040, 32'hFFFF_FFFE, 4'h4, 32'h0,         1'b0};
        vecs[13] = '{1'b0, 12'h040, 32'h0,         4'h0, 32'h2,         1'b0};
        vecs[14] = '{1'b0, 12'h050, 32'h0,         4'h4, 32'h1,         1'b0};
        vecs[15] = '{1'b1, 12'h014, 32'h1,         4'h0, 32'h0,         1'b1};
        vecs[16] = '{1'b1, 12'h040, 32'h3,         4'h4, 32'h0,         1'b1};
        vecs[17] = '{1'b0, 12'h104, 32'h0,         4'h0, 32'h0,         1'b0};
        vecs[18] = '{1'b1, 12'h068, 32'hCAFE_F00D, 4'h0, 32'h0,         1'b0};
        vecs[19] = '{1'b0, 12'h068, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0};
        vecs[20] = '{1'b1, 12'h200, 32'h1,         4'h0, 32'h0,         1'b1};
        vecs[21] = '{1'b0, 12'h040, 32'h0,         4'h0, 32'h2,         1'b0};

        HRESET = 1'b1; PADDR = '0; PWDATA = '0; PWRITE = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        ch_busy = '0; ch_done = '0; ch_err = '0;
        repeat (3) @(negedge HCLK);
        check("reset PREADY",  {31'b0, PREADY},  32'h0);
        check("reset PSLVERR", {31'b0, PSLVERR}, 32'h0);
        check("reset PRDATA",  PRDATA,           32'h0);
        check("reset ch_start", {28'b0, ch_start}, 32'h0);
        check("reset irq",     {31'b0, irq},     32'h0);
        check("reset ch_src0", ch_src[0],        32'h0);
        check("reset ch_len3", {16'b0, ch_len[3]}, 32'h0);
        HRESET = 1'b0;

        for (int i = 0; i < 22; i++) begin
            ch_busy = vecs[i].busy;
            apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, '0, rd, err, lat);
            check($sformatf("vec%0d rdata", i), rd, vecs[i].rdata);
            check($sformatf("vec%0d slverr", i), {31'b0, err}, {31'b0, vecs[i].err});
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(WS + 1));
        end
        ch_busy = '0;
        check("table no start pulses", 32'(start_total), 32'h0);
        check("ch_src1 output", ch_src[1], 32'h1000_0000);
        check("ch_dst3 output", ch_dst[3], 32'hCAFE_F00D);

        // Channel 0 start, done, interrupt and W1C
        wr_chk("ch0 len", 12'h00C, 32'h8, '0);
        check("ch_len0 output", {16'b0, ch_len[0]}, 32'h8);
        s0 = start_total;
        wr_chk("ch0 start", 12'h000, 32'h3, '0);
        check("ch_start after start", {28'b0, ch_start}, 32'h1);
        @(negedge HCLK);
        check("ch_start one cycle", {28'b0, ch_start}, 32'h0);
        check("start pulse count", 32'(start_total - s0), 32'h1);
        rd_chk("ch0 ctrl start reads 0", 12'h000, 32'h2);
        @(negedge HCLK); ch_done[0] = 1'b1;
        @(negedge HCLK); ch_done[0] = 1'b0;
        check("irq not yet", {31'b0, irq}, 32'h0);
        @(negedge HCLK);
        check("irq after done", {31'b0, irq}, 32'h1);
        rd_chk("ch0 status done", 12'h010, 32'h2);
        rd_chk("irq_status", 12'h104, 32'h1);
        wr_chk("ch0 w1c", 12'h010, 32'h2, '0);
        @(negedge HCLK);
        check("irq after w1c", {31'b0, irq}, 32'h0);
        rd_chk("ch0 status clear", 12'h010, 32'h0);

        // Channel 3: done set coinciding with W1C, then error flag
        @(negedge HCLK); ch_done[3] = 1'b1;
        @(negedge HCLK); ch_done[3] = 1'b0;
        rd_chk("ch3 status done", 12'h070, 32'h2);
        wr_chk("ch3 w1c with done", 12'h070, 32'h2, 4'b1000);
        rd_chk("ch3 set wins", 12'h070, 32'h2);
        wr_chk("ch3 w1c plain", 12'h070, 32'h2, '0);
        rd_chk("ch3 done cleared", 12'h070, 32'h0);
        @(negedge HCLK); ch_err[3] = 1'b1;
        @(negedge HCLK); ch_err[3] = 1'b0;
        rd_chk("ch3 status err", 12'h070, 32'h4);
        wr_chk("ch3 w1c err", 12'h070, 32'h4, '0);
        rd_chk("ch3 err cleared", 12'h070, 32'h0);

        // PENABLE dropped during ACCESS aborts the write
        rdy = 0;
        @(negedge HCLK); PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h004; PWDATA = 32'hAAAA_5555;
        @(negedge HCLK); PENABLE = 1'b1;
        @(negedge HCLK); rdy += int'(PREADY); PENABLE = 1'b0; PSEL = 1'b0; PWRITE = 1'b0;
        repeat (3) begin @(negedge HCLK); rdy += int'(PREADY); end
        check("abort no pready", 32'(rdy), 32'h0);
        check("abort no write", ch_src[0], 32'h0);
        apb_xfer(1'b0, 12'h004, '0, '0, rd, err, lat);
        check("after abort latency", 32'(lat), 32'(WS + 1));
        check("after abort rdata", rd, 32'h0);

        // Reset in the middle of an ACCESS
        wr_chk("ch0 src pre", 12'h004, 32'h5A5A_5A5A, '0);
        rdy = 0;
        @(negedge HCLK); PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h004; PWDATA = 32'hFFFF_FFFF;
        @(negedge HCLK); PENABLE = 1'b1;
        @(negedge HCLK); rdy += int'(PREADY); HRESET = 1'b1;
        repeat (2) begin @(negedge HCLK); rdy += int'(PREADY); end
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        @(negedge HCLK); rdy += int'(PREADY); HRESET = 1'b0;
        check("reset abort no pready", 32'(rdy), 32'h0);
        check("reset ch_src0 out", ch_src[0], 32'h0);
        rd_chk("src ch0 after reset", 12'h004, 32'h0);
        rd_chk("src ch1 after reset", 12'h024, 32'h0);
        rd_chk("ctrl ch2 after reset", 12'h040, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
